// File: rtl/ysyx_25060166_mem_rsp_pkg.sv
// Shared RV32E definitions (data width, FSM encodings, LFSR seed) and mem_rsp types.
// The LFSR seed is used only when YSYX_25060166_MEM_RANDDLY_EN is defined.
`ifndef YSYX_25060166_RV32E_VH
`define YSYX_25060166_RV32E_VH
`define ysyx_25060166_WIDTH 32
`define ysyx_25060166_MEM_ST_IDLE 2'd0
`define ysyx_25060166_MEM_ST_WAIT 2'd1
`define ysyx_25060166_MEM_ST_RESP 2'd2
`define ysyx_25060166_MEM_LFSR_SEED 4'b1001
`endif

package ysyx_25060166_mem_rsp_pkg;

  typedef enum logic [1:0] {
    StIdle = `ysyx_25060166_MEM_ST_IDLE,
    StWait = `ysyx_25060166_MEM_ST_WAIT,
    StResp = `ysyx_25060166_MEM_ST_RESP
  } state_e;

  // Wide enough for RD_LAT (max 7) plus up to 3 random extra cycles.
  localparam int unsigned CntW = 4;

  // Fibonacci LFSR for x^4 + x^3 + 1.
  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/ysyx_25060166_mem_rsp_array.sv
// Word-addressed storage with byte-strobed synchronous write and registered read.
module ysyx_25060166_mem_array #(
  parameter int unsigned DepthLog2 = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [DepthLog2-1:0] idx_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wstrb_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**DepthLog2];
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[idx_i];
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_25060166_mem_rsp.sv
// Single-outstanding memory responder with fixed (or, with YSYX_25060166_MEM_RANDDLY_EN,
// LFSR-jittered) latency from request accept to response.
module ysyx_25060166_mem_rsp
  import ysyx_25060166_mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_wen,
  input  logic [`ysyx_25060166_WIDTH-1:0] req_addr,
  input  logic [31:0]                     req_wdata,
  input  logic [3:0]                      req_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic                            rsp_err
);

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            err_d, err_q;
  logic            wen_d, wen_q;
  logic            accept, addr_err;
  logic [CntW-1:0] delay;
  logic [31:0]     arr_rdata;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign addr_err  = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != '0);

`ifdef YSYX_25060166_MEM_RANDDLY_EN
  logic [3:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= `ysyx_25060166_MEM_LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign delay = CntW'(RD_LAT) + {2'b00, lfsr_q[1:0]};
`else
  assign delay = CntW'(RD_LAT);
`endif

  ysyx_25060166_mem_array #(
    .DepthLog2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (accept & req_wen & ~addr_err),
    .re_i   (accept & ~req_wen & ~addr_err),
    .idx_i  (req_addr[DEPTH_LOG2+1:2]),
    .wdata_i(req_wdata),
    .wstrb_i(req_wstrb),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wen_d   = wen_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d = addr_err;
          wen_d = req_wen;
          if (delay == CntW'(1)) begin
            state_d = StResp;
            cnt_d   = '0;
          end else begin
            state_d = StWait;
            cnt_d   = delay - CntW'(2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data only surfaces for successful reads; the array output is held since re
  // fires only at accept.
  always_comb begin
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = (rsp_valid & ~err_q & ~wen_q) ? arr_rdata : 32'h0;
  end

endmodule

// File: tb/tb_ysyx_25060166_mem_rsp.sv
// Scoreboard bench for ysyx_25060166_mem_rsp: instance 0 at RD_LAT=1, instance 1 at RD_LAT=3.
module tb_ysyx_25060166_mem_rsp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic        req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rsp_rdata [2];

  exp_t        sb[$];
  logic [31:0] mdl[int];
  int          rd_lat[2] = '{1, 3};
  int          n_vec = 0;
  int          n_bad = 0;
`ifdef YSYX_25060166_MEM_RANDDLY_EN
  logic [3:0]  lfsr_m[2] = '{4'b1001, 4'b1001};
`endif

  always #5 clk = ~clk;

  ysyx_25060166_mem_rsp #(.DEPTH_LOG2(10), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  ysyx_25060166_mem_rsp #(.DEPTH_LOG2(10), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns 1ns after the accepting posedge.
  task automatic issue(input int s, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    int          w = 0;
    int          key;
    exp_t        e;
    logic [31:0] old;
    while (!req_ready[s] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_idle", 32'(req_ready[s]), 32'd1);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid[s] = 1'b1;
    key = s * 1024 + int'(addr[11:2]);
    if (addr[1:0] != 2'b00 || addr[31:12] != 20'h0) begin
      e.rdata = 32'h0; e.err = 1'b1;
    end else if (wen) begin
      e.rdata = 32'h0; e.err = 1'b0;
      old = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (wstrb[b]) old[8*b +: 8] = wdata[8*b +: 8];
      mdl[key] = old;
    end else begin
      e.rdata = mdl.exists(key) ? mdl[key] : 32'h0; e.err = 1'b0;
    end
`ifdef YSYX_25060166_MEM_RANDDLY_EN
    e.lat = rd_lat[s] + int'(lfsr_m[s][1:0]);
    lfsr_m[s] = {lfsr_m[s][2:0], lfsr_m[s][3] ^ lfsr_m[s][2]};
`else
    e.lat = rd_lat[s];
`endif
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid[s] = 1'b0;
  endtask

  // Waits for the response, checks it, optionally stalls `hold` cycles, then handshakes.
  task automatic collect(input int s, input int hold);
    int   lat = 0;
    exp_t e;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[s] && lat < 20);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("rsp_rdata", rsp_rdata[s], e.rdata);
    check("rsp_err", 32'(rsp_err[s]), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[s]), 32'd1);
      check("hold_rdata", rsp_rdata[s], e.rdata);
      check("hold_req_ready", 32'(req_ready[s]), 32'd0);
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[s] = 1'b0;
    @(negedge clk);
    check("valid_after_hs", 32'(rsp_valid[s]), 32'd0);
    check("ready_after_hs", 32'(req_ready[s]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[s], 32'h0);
      check("reset_rsp_err", 32'(rsp_err[s]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset0", 32'(req_ready[0]), 32'd1);
    check("ready_after_reset1", 32'(req_ready[1]), 32'd1);

    // Basic write then read.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); collect(0, 0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);        collect(0, 0);
    // Empty strobe writes nothing but still acks.
    issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0); collect(0, 0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);        collect(0, 0);
    // Byte strobes over a zeroed word.
    issue(0, 1'b1, 32'h20, 32'h0, 4'hF);        collect(0, 0);
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'h5); collect(0, 0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);        collect(0, 0);
    // Errors: misaligned read, out-of-range write must not alias word 0.
    issue(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);  collect(0, 0);
    issue(0, 1'b0, 32'h13, 32'h0, 4'h0);        collect(0, 0);
    issue(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF); collect(0, 0);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0);         collect(0, 0);

    // Backpressure on the RD_LAT=3 instance.
    issue(1, 1'b1, 32'h40, 32'h55AA55AA, 4'hF); collect(1, 0);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0);        collect(1, 5);

    // Reset while waiting: response dropped, committed write kept.
    issue(1, 1'b1, 32'h8, 32'h12345678, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
`ifdef YSYX_25060166_MEM_RANDDLY_EN
    lfsr_m[0] = 4'b1001; lfsr_m[1] = 4'b1001;
`endif
    @(negedge clk);
    check("rst_mid_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_mid_ready", 32'(req_ready[1]), 32'd1);
    issue(1, 1'b0, 32'h8, 32'h0, 4'h0);         collect(1, 0);

    // Back-to-back reads; latency tracks the delay model each time.
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
      collect(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
